// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the register write arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE=0, LOCKED=1)
//   wrap_inc    : modulo-n increment used for the round-robin pointer
//   id_width    : width of a requester index, never less than one bit
package reg_write_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req    : request vector, one bit per requester
//   rr_ptr : index with highest priority; priority falls off upward mod N
//   valid  : at least one request present
//   index  : first requesting index found from rr_ptr upward, wrapping
module reg_write_arbiter_rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] rr_ptr,
  output logic           valid,
  output logic [IDW-1:0] index
);

  // Scan offsets from the farthest down to zero so the closest request
  // to rr_ptr is the last assignment and therefore wins.
  always_comb begin : pick
    int j;
    logic [IDW-1:0] jj;
    j     = 0;
    jj    = '0;
    valid = 1'b0;
    index = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= N) j = j - N;
      jj = IDW'(j);
      if (req[jj]) begin
        valid = 1'b1;
        index = jj;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter in front of a single WIDTH-bit Register.
// One write per cycle; a requester may lock the Register for a bounded
// number of cycles (MAX_LOCK) to perform read-modify-write sequences.
//   clock, reset : system clock, synchronous active-high reset
//   req, lock    : per-requester request and lock-keep bits
//   wdata        : requester i data at [i*WIDTH +: WIDTH]
//   ack          : one-hot, one-cycle pulse when requester i was written
//   grant_id     : index of the requester written (valid with reg_load)
//   reg_in       : Register data, holds its last value when not loading
//   reg_load     : Register load strobe
//   busy         : high while the FSM is in LOCKED
//   lock_timeout : one-cycle pulse on a forced lock release
//   state_dbg    : current FSM state (0=IDLE, 1=LOCKED)
//
// Handshake: req[i] is a level; it is sampled every cycle. A write of
// requester i is reported by ack[i] one cycle after the sampling edge,
// and a req[i] still high in the cycle ack[i] is visible counts as a new
// request. Every output is a flop, so all responses lag inputs by one cycle.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int N        = 4,
  parameter int MAX_LOCK = 8,
  localparam int IDW     = id_width(N),
  localparam int CW      = $clog2(MAX_LOCK + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N-1:0]       req,
  input  logic [N-1:0]       lock,
  input  logic [N*WIDTH-1:0] wdata,
  output logic [N-1:0]       ack,
  output logic [IDW-1:0]     grant_id,
  output logic [WIDTH-1:0]   reg_in,
  output logic               reg_load,
  output logic               busy,
  output logic               lock_timeout,
  output logic               state_dbg
);

  arb_state_e       state_q, state_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]    lock_cnt_q, lock_cnt_d;
  logic [N-1:0]     ack_q, ack_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic [WIDTH-1:0] reg_in_q, reg_in_d;
  logic             reg_load_q, reg_load_d;
  logic             busy_q, busy_d;
  logic             lock_timeout_q, lock_timeout_d;

  logic             pick_valid;
  logic [IDW-1:0]   pick_idx;
  logic             forced;

  reg_write_arbiter_rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .index  (pick_idx)
  );

  // A lock that has run MAX_LOCK cycles is released and the cycle is
  // arbitrated like IDLE; the owner competes again on equal terms.
  assign forced = (state_q == ST_LOCKED) && (lock_cnt_q == CW'(MAX_LOCK));

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    rr_ptr_d       = rr_ptr_q;
    lock_cnt_d     = lock_cnt_q;
    ack_d          = '0;
    grant_id_d     = grant_id_q;
    reg_in_d       = reg_in_q;
    reg_load_d     = 1'b0;
    lock_timeout_d = 1'b0;

    if (state_q == ST_IDLE || forced) begin
      lock_timeout_d = forced;
      state_d        = ST_IDLE;
      lock_cnt_d     = '0;
      if (pick_valid) begin
        ack_d      = N'(1) << pick_idx;
        grant_id_d = pick_idx;
        reg_in_d   = wdata[int'(pick_idx)*WIDTH +: WIDTH];
        reg_load_d = 1'b1;
        rr_ptr_d   = IDW'(wrap_inc(int'(pick_idx), N));
        if (lock[pick_idx]) begin
          state_d    = ST_LOCKED;
          owner_d    = pick_idx;
          lock_cnt_d = CW'(1);
        end
      end
    end else begin
      // LOCKED: the picker result is ignored; only the owner is served.
      if (req[owner_q]) begin
        ack_d      = N'(1) << owner_q;
        grant_id_d = owner_q;
        reg_in_d   = wdata[int'(owner_q)*WIDTH +: WIDTH];
        reg_load_d = 1'b1;
      end
      if (lock[owner_q]) begin
        lock_cnt_d = lock_cnt_q + CW'(1);
      end else begin
        state_d    = ST_IDLE;
        lock_cnt_d = '0;
      end
    end

    busy_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      owner_q        <= '0;
      rr_ptr_q       <= '0;
      lock_cnt_q     <= '0;
      ack_q          <= '0;
      grant_id_q     <= '0;
      reg_in_q       <= '0;
      reg_load_q     <= 1'b0;
      busy_q         <= 1'b0;
      lock_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      rr_ptr_q       <= rr_ptr_d;
      lock_cnt_q     <= lock_cnt_d;
      ack_q          <= ack_d;
      grant_id_q     <= grant_id_d;
      reg_in_q       <= reg_in_d;
      reg_load_q     <= reg_load_d;
      busy_q         <= busy_d;
      lock_timeout_q <= lock_timeout_d;
    end
  end

  assign ack          = ack_q;
  assign grant_id     = grant_id_q;
  assign reg_in       = reg_in_q;
  assign reg_load     = reg_load_q;
  assign busy         = busy_q;
  assign lock_timeout = lock_timeout_q;
  assign state_dbg    = state_q;

endmodule
